// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and default sizes for the LIF neuron slice
package snn_pkg;

    localparam int N_SYN     = 16;
    localparam int W_W       = 4;
    localparam int V_W       = 8;
    localparam int SYN_IDX_W = $clog2(N_SYN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAK  = 2'd1,
        ACCUM = 2'd2,
        FIRE  = 2'd3
    } lif_state_t;

    typedef enum logic [1:0] {
        ALU_HOLD = 2'd0,
        ALU_LEAK = 2'd1,
        ALU_ADD  = 2'd2
    } alu_mode_t;

endpackage

// File: rtl/lif_membrane_alu.sv
// rtl/lif_membrane_alu.sv - combinational leak / saturating add / threshold compare
module lif_membrane_alu
    import snn_pkg::*;
#(
    parameter int V_W        = 8,
    parameter int W_W        = 4,
    parameter int THRESH     = 20,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [V_W-1:0] v_i,
    input  logic [W_W-1:0] weight_i,
    input  alu_mode_t      mode_i,
    output logic [V_W-1:0] v_o,
    output logic           fire_o
);

    localparam logic [V_W:0] THRESH_V = (V_W+1)'(THRESH);

    logic [V_W:0]   sum;
    logic [V_W-1:0] sat_sum;
    logic [V_W-1:0] leaked;

    // One extra bit catches the carry so the add can clamp at all-ones.
    assign sum     = {1'b0, v_i} + {{(V_W+1-W_W){1'b0}}, weight_i};
    assign sat_sum = sum[V_W] ? '1 : sum[V_W-1:0];
    assign leaked  = v_i - (v_i >> LEAK_SHIFT);
    assign fire_o  = ({1'b0, v_i} >= THRESH_V);

    always_comb begin
        v_o = v_i;
        case (mode_i)
            ALU_LEAK: v_o = leaked;
            ALU_ADD:  v_o = sat_sum;
            default:  v_o = v_i;
        endcase
    end

endmodule

// File: rtl/lif_neuron_seq.sv
// rtl/lif_neuron_seq.sv - sequential leaky-integrate-and-fire neuron over N_SYN synapses
module lif_neuron_seq
    import snn_pkg::*;
#(
    parameter int N_SYN      = snn_pkg::N_SYN,
    parameter int W_W        = snn_pkg::W_W,
    parameter int V_W        = snn_pkg::V_W,
    parameter int THRESH     = 20,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    localparam int IDX_W     = $clog2(N_SYN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic [N_SYN-1:0] pre_spike,
    input  logic [W_W-1:0]   weight_in,
    output logic [IDX_W-1:0] weight_sel,
    output logic             post_spike,
    output logic             done,
    output logic             busy,
    output logic [V_W-1:0]   membrane,
    output logic             overrun
);

    localparam int RC_W = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYN - 1);

    lif_state_t       state_q, state_d;
    logic [V_W-1:0]   v_q, v_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RC_W-1:0]  refrac_q, refrac_d;
    logic [N_SYN-1:0] pre_q, pre_d;
    logic             post_q, post_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    alu_mode_t        alu_mode;
    logic [V_W-1:0]   alu_v;
    logic             alu_fire;

    lif_membrane_alu #(
        .V_W        (V_W),
        .W_W        (W_W),
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_alu (
        .v_i      (v_q),
        .weight_i (weight_in),
        .mode_i   (alu_mode),
        .v_o      (alu_v),
        .fire_o   (alu_fire)
    );

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        idx_d     = idx_q;
        refrac_d  = refrac_q;
        pre_d     = pre_q;
        post_d    = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        alu_mode  = ALU_HOLD;

        // A step that arrives mid-timestep is dropped, but remembered.
        if (step && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (step) begin
                    pre_d   = pre_spike;
                    idx_d   = '0;
                    state_d = LEAK;
                end
            end
            LEAK: begin
                alu_mode = ALU_LEAK;
                v_d      = alu_v;
                state_d  = ACCUM;
            end
            ACCUM: begin
                if (pre_q[idx_q] && (refrac_q == '0)) begin
                    alu_mode = ALU_ADD;
                    v_d      = alu_v;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = FIRE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FIRE: begin
                done_d = 1'b1;
                if ((refrac_q == '0) && alu_fire) begin
                    post_d   = 1'b1;
                    v_d      = '0;
                    refrac_d = RC_W'(REFRAC);
                end else if (refrac_q != '0) begin
                    refrac_d = refrac_q - RC_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            v_q       <= '0;
            idx_q     <= '0;
            refrac_q  <= '0;
            pre_q     <= '0;
            post_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            idx_q     <= idx_d;
            refrac_q  <= refrac_d;
            pre_q     <= pre_d;
            post_q    <= post_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign weight_sel = (state_q == ACCUM) ? idx_q : '0;
    assign post_spike = post_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
    assign membrane   = v_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_lif_neuron_seq.sv
// tb/tb_lif_neuron_seq.sv - self-checking bench for lif_neuron_seq against a timestep model
module tb_lif_neuron_seq;

    logic        clock;
    logic        reset;
    logic        step, step_s;
    logic [15:0] pre_spike;
    logic [3:0]  wmem [16];
    logic [3:0]  weight_in, weight_in_s;
    logic [3:0]  weight_sel, weight_sel_s;
    logic        post_spike, post_spike_s;
    logic        done, done_s;
    logic        busy, busy_s;
    logic [7:0]  membrane, membrane_s;
    logic        overrun, overrun_s;

    int vectors;
    int miscompares;
    int m_v, m_rc;
    int s_v, s_rc;

    assign weight_in   = wmem[weight_sel];
    assign weight_in_s = wmem[weight_sel_s];

    lif_neuron_seq dut (
        .clock      (clock),
        .reset      (reset),
        .step       (step),
        .pre_spike  (pre_spike),
        .weight_in  (weight_in),
        .weight_sel (weight_sel),
        .post_spike (post_spike),
        .done       (done),
        .busy       (busy),
        .membrane   (membrane),
        .overrun    (overrun)
    );

    lif_neuron_seq #(.THRESH(255)) dut_sat (
        .clock      (clock),
        .reset      (reset),
        .step       (step_s),
        .pre_spike  (pre_spike),
        .weight_in  (weight_in_s),
        .weight_sel (weight_sel_s),
        .post_spike (post_spike_s),
        .done       (done_s),
        .busy       (busy_s),
        .membrane   (membrane_s),
        .overrun    (overrun_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One whole timestep in plain arithmetic: leak, sum of active weights, fire decision.
    task automatic model_step(input logic [15:0] pre, input int thresh, inout int v, inout int rc,
                              output bit fire, output int vpre);
        v = v - (v >> 3);
        if (rc == 0) begin
            for (int i = 0; i < 16; i++) begin
                if (pre[i]) begin
                    v = v + int'(wmem[i]);
                    if (v > 255) v = 255;
                end
            end
        end
        vpre = v;
        fire = 1'b0;
        if (rc == 0 && v >= thresh) begin
            fire = 1'b1;
            v    = 0;
            rc   = 2;
        end else if (rc > 0) begin
            rc = rc - 1;
        end
    endtask

    task automatic set_weights(input int mode, input int val);
        for (int i = 0; i < 16; i++) wmem[i] = (mode == 0) ? 4'(val) : 4'($urandom_range(0, 15));
    endtask

    // Starts one timestep from IDLE; returns at the cycle where done is seen (or after a bound).
    task automatic run_step(input bit sat, input logic [15:0] pre, input int pulse_at,
                            output int lat, output logic post, output logic [7:0] vpre,
                            output logic [7:0] vafter);
        logic [7:0] prev_mem;
        lat = -1; post = 1'b0; vpre = '0; vafter = '0; prev_mem = '0;
        pre_spike = pre;
        if (sat) step_s = 1'b1; else step = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (k == 0) begin step = 1'b0; step_s = 1'b0; end
            if (k == 2) pre_spike = ~pre;
            if (k == pulse_at - 1) begin if (sat) step_s = 1'b1; else step = 1'b1; end
            if (k == pulse_at) begin step = 1'b0; step_s = 1'b0; end
            if ((sat ? done_s : done) === 1'b1) begin
                lat    = k;
                post   = sat ? post_spike_s : post_spike;
                vafter = sat ? membrane_s : membrane;
                vpre   = prev_mem;
                break;
            end
            prev_mem = sat ? membrane_s : membrane;
        end
    endtask

    task automatic test_reset();
        logic [7:0] mem_before;
        int seen;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step = 1'($urandom); step_s = 1'($urandom); pre_spike = 16'($urandom);
            set_weights(1, 0);
            @(negedge clock);
            vectors++;
            if ({post_spike, done, busy, overrun, weight_sel, membrane} !== 16'h0) begin
                miscompares++;
                $display("FAIL reset_hold: got %h expected 0",
                         {post_spike, done, busy, overrun, weight_sel, membrane});
            end
        end
        step = 1'b0; step_s = 1'b0; pre_spike = 16'hFFFF;
        set_weights(0, 2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        step = 1'b1;
        @(posedge clock);
        @(negedge clock);
        step = 1'b0;
        seen = 0;
        for (int k = 0; k < 30 && seen == 0; k++) begin
            if (weight_sel === 4'd7) seen = 1;
            else @(negedge clock);
        end
        mem_before = membrane;
        reset = 1'b0;
        #1;
        vectors++;
        if (seen != 1 || mem_before !== 8'd14) begin
            miscompares++;
            $display("FAIL reset_mid_setup: reached_idx7=%0d membrane=%0d expected 1/14", seen, mem_before);
        end
        vectors++;
        if (membrane !== 8'd0 || busy !== 1'b0 || weight_sel !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: membrane=%0d busy=%b sel=%0d expected 0/0/0",
                     membrane, busy, weight_sel);
        end
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            if (done === 1'b1 || post_spike === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_abort: got %0d done/spike cycles expected 0", seen);
        end
        m_v = 0; m_rc = 0; s_v = 0; s_rc = 0;
    endtask

    task automatic test_fire();
        int lat, vp; bit f; logic post; logic [7:0] vpre, vaft;
        set_weights(0, 2);
        model_step(16'hFFFF, 20, m_v, m_rc, f, vp);
        run_step(1'b0, 16'hFFFF, 0, lat, post, vpre, vaft);
        vectors++;
        if (lat !== 18 || post !== f || vpre !== 8'(vp) || vaft !== 8'(m_v)) begin
            miscompares++;
            $display("FAIL fire: lat=%0d post=%b vpre=%0d vafter=%0d expected 18/%b/%0d/%0d",
                     lat, post, vpre, vaft, f, vp, m_v);
        end
    endtask

    task automatic test_refractory();
        int lat, vp; bit f; logic post; logic [7:0] vpre, vaft;
        for (int t = 2; t <= 4; t++) begin
            model_step(16'hFFFF, 20, m_v, m_rc, f, vp);
            run_step(1'b0, 16'hFFFF, 0, lat, post, vpre, vaft);
            vectors++;
            if (lat !== 18 || post !== f || vpre !== 8'(vp) || vaft !== 8'(m_v)) begin
                miscompares++;
                $display("FAIL refrac_t%0d: lat=%0d post=%b vpre=%0d vafter=%0d expected 18/%b/%0d/%0d",
                         t, lat, post, vpre, vaft, f, vp, m_v);
            end
        end
    endtask

    task automatic test_leak();
        int lat, vp; bit f; logic post; logic [7:0] vpre, vaft;
        logic [15:0] pres [2];
        pres[0] = 16'h001F; pres[1] = 16'h0000;
        for (int t = 0; t < 2; t++) begin
            model_step(pres[t], 20, m_v, m_rc, f, vp);
            run_step(1'b0, pres[t], 0, lat, post, vpre, vaft);
            vectors++;
            if (lat !== 18 || post !== f || vaft !== 8'(m_v)) begin
                miscompares++;
                $display("FAIL leak_t%0d: lat=%0d post=%b membrane=%0d expected 18/%b/%0d",
                         t, lat, post, vaft, f, m_v);
            end
        end
    endtask

    task automatic test_saturation();
        int lat, vp; bit f; logic post; logic [7:0] vpre, vaft;
        set_weights(0, 8);
        for (int t = 0; t < 3; t++) begin
            model_step(16'hFFFF, 255, s_v, s_rc, f, vp);
            run_step(1'b1, 16'hFFFF, 0, lat, post, vpre, vaft);
            vectors++;
            if (lat !== 18 || post !== f || vpre !== 8'(vp) || vaft !== 8'(s_v)) begin
                miscompares++;
                $display("FAIL sat_t%0d: lat=%0d post=%b vpre=%0d vafter=%0d expected 18/%b/%0d/%0d",
                         t, lat, post, vpre, vaft, f, vp, s_v);
            end
        end
    endtask

    task automatic test_overrun();
        int lat, vp; bit f; logic post; logic [7:0] vpre, vaft; logic [15:0] pre;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_initial: got %b expected 0", overrun);
        end
        for (int t = 0; t < 2; t++) begin
            set_weights(1, 0);
            pre = 16'($urandom);
            model_step(pre, 20, m_v, m_rc, f, vp);
            run_step(1'b0, pre, (t == 0) ? 5 : 0, lat, post, vpre, vaft);
            vectors++;
            if (lat !== 18 || post !== f || vpre !== 8'(vp) || vaft !== 8'(m_v) || overrun !== 1'b1) begin
                miscompares++;
                $display("FAIL overrun_t%0d: lat=%0d post=%b vpre=%0d vafter=%0d ovr=%b expected 18/%b/%0d/%0d/1",
                         t, lat, post, vpre, vaft, overrun, f, vp, m_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pres [3];
        int t, r, exp_ws, vp; bit f, exp_done, exp_busy;
        set_weights(1, 0);
        for (int i = 0; i < 3; i++) pres[i] = 16'($urandom);
        step = 1'b1;
        pre_spike = pres[0];
        @(posedge clock);
        for (int k = 0; k < 61; k++) begin
            @(negedge clock);
            if (k == 5)  pre_spike = pres[1];
            if (k == 24) pre_spike = pres[2];
            if (k == 38) step = 1'b0;
            if (k == 43) pre_spike = 16'($urandom);
            t = k / 19;
            r = k % 19;
            exp_ws   = (t < 3 && r >= 1 && r <= 16) ? r - 1 : 0;
            exp_done = (t < 3 && r == 18);
            exp_busy = (t < 3 && r <= 17);
            vectors++;
            if (weight_sel !== 4'(exp_ws) || done !== exp_done || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL b2b_seq k=%0d: sel=%0d done=%b busy=%b expected %0d/%b/%b",
                         k, weight_sel, done, busy, exp_ws, exp_done, exp_busy);
            end
            if (exp_done) begin
                model_step(pres[t], 20, m_v, m_rc, f, vp);
                vectors++;
                if (post_spike !== f || membrane !== 8'(m_v)) begin
                    miscompares++;
                    $display("FAIL b2b_result t=%0d: post=%b membrane=%0d expected %b/%0d",
                             t, post_spike, membrane, f, m_v);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, vp; bit f; logic post; logic [7:0] vpre, vaft; logic [15:0] pre;
        for (int t = 0; t < 24; t++) begin
            set_weights(1, 0);
            pre = 16'($urandom) & 16'($urandom | $urandom);
            model_step(pre, 20, m_v, m_rc, f, vp);
            run_step(1'b0, pre, 0, lat, post, vpre, vaft);
            vectors++;
            if (lat !== 18 || post !== f || vpre !== 8'(vp) || vaft !== 8'(m_v)) begin
                miscompares++;
                $display("FAIL random_t%0d: lat=%0d post=%b vpre=%0d vafter=%0d expected 18/%b/%0d/%0d",
                         t, lat, post, vpre, vaft, f, vp, m_v);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_v = 0; m_rc = 0; s_v = 0; s_rc = 0;
        reset = 1'b0; step = 1'b0; step_s = 1'b0; pre_spike = '0;
        set_weights(0, 0);
        @(negedge clock);
        test_reset();
        test_fire();
        test_refractory();
        test_leak();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
